// File: rtl/nexys_starship_dispatch_if.sv
// Bundle between button/terminal logic and the monster dispatch block.
// master drives requests and terminal flags; slave is the dispatcher.
interface nexys_starship_dispatch_if #(
  parameter int SCORE_W = 8
);
  logic               start;
  logic [3:0]         monster;
  logic [3:0]         gameover_in;
  logic               play_flag;
  logic               gameover_ctrl;
  logic [3:0]         rand_out;
  logic [SCORE_W-1:0] score;
  logic               q_Idle;
  logic               q_Play;
  logic               q_Over;

  modport master (
    output start,
    output monster,
    output gameover_in,
    input  play_flag,
    input  gameover_ctrl,
    input  rand_out,
    input  score,
    input  q_Idle,
    input  q_Play,
    input  q_Over
  );

  modport slave (
    input  start,
    input  monster,
    input  gameover_in,
    output play_flag,
    output gameover_ctrl,
    output rand_out,
    output score,
    output q_Idle,
    output q_Play,
    output q_Over
  );
endinterface

// File: rtl/nexys_starship_dispatch.sv
// Game-side dispatcher: play/gameover control, random spawns
// for the four monster terminals and a saturating kill score.
module nexys_starship_dispatch #(
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter logic [7:0]  RAND_THRESH = 8'd64,
  parameter int          MAX_ACTIVE  = 2,
  parameter int          SCORE_W     = 8
) (
  input logic                     timer_clk,
  input logic                     Reset,
  nexys_starship_dispatch_if.slave bus
);

  localparam logic [15:0] SEED =
    (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] MASK  = 16'hB400;
  localparam logic [2:0]  MAX_A = 3'(MAX_ACTIVE);
  localparam int          SW    = SCORE_W + 3;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    OVER = 2'b10
  } state_t;

  state_t state;
  state_t state_nxt;

  logic               start_m;
  logic               start_s;
  logic [3:0]         mon_m;
  logic [3:0]         mon_s;
  logic [3:0]         go_m;
  logic [3:0]         go_s;
  logic [3:0]         prev_mon;
  logic [15:0]        lfsr;

  logic               play_q;
  logic               play_nxt;
  logic               over_q;
  logic               over_nxt;
  logic [3:0]         rand_q;
  logic [3:0]         rand_nxt;
  logic [SCORE_W-1:0] score_q;
  logic [SCORE_W-1:0] score_nxt;

  logic               st_idle;
  logic               st_play;
  logic               st_over;
  logic [1:0]         idx;
  logic               spawn_ok;
  logic [3:0]         spawn_vec;
  logic [2:0]         kills;
  logic [SW-1:0]      sum;
  logic [SCORE_W-1:0] score_sat;

  function automatic logic [2:0] pop4(input logic [3:0] v);
    pop4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  always_ff @(posedge timer_clk or posedge Reset) begin
    if (Reset) begin
      start_m  <= 1'b0;
      start_s  <= 1'b0;
      mon_m    <= '0;
      mon_s    <= '0;
      go_m     <= '0;
      go_s     <= '0;
      prev_mon <= '0;
    end else begin
      start_m  <= bus.start;
      start_s  <= start_m;
      mon_m    <= bus.monster;
      mon_s    <= mon_m;
      go_m     <= bus.gameover_in;
      go_s     <= go_m;
      prev_mon <= mon_s;
    end
  end

  // Galois form; a nonzero seed can never collapse to zero
  always_ff @(posedge timer_clk or posedge Reset) begin
    if (Reset) begin
      lfsr <= SEED;
    end else if (lfsr[0]) begin
      lfsr <= (lfsr >> 1) ^ MASK;
    end else begin
      lfsr <= lfsr >> 1;
    end
  end

  assign idx       = lfsr[1:0];
  assign spawn_ok  = (lfsr[9:2] < RAND_THRESH)
                   && !mon_s[idx]
                   && (pop4(mon_s) < MAX_A);
  assign spawn_vec = spawn_ok ? (4'b0001 << idx) : 4'b0000;

  assign kills     = pop4(prev_mon & ~mon_s);
  assign sum       = SW'(score_q) + SW'(kills);
  assign score_sat = (sum > SW'(SCORE_MAX))
                   ? SCORE_MAX : sum[SCORE_W-1:0];

  assign st_idle = (state == IDLE);
  assign st_play = (state == PLAY);
  assign st_over = (state == OVER);

  // an unlisted encoding falls to default and lands in IDLE
  always_comb begin
    state_nxt = IDLE;
    play_nxt  = 1'b0;
    over_nxt  = 1'b0;
    rand_nxt  = '0;
    score_nxt = score_q;
    unique case (1'b1)
      st_idle: begin
        if (start_s) begin
          state_nxt = PLAY;
          play_nxt  = 1'b1;
          score_nxt = '0;
        end
      end
      st_play: begin
        if (|go_s) begin
          state_nxt = OVER;
          over_nxt  = 1'b1;
        end else begin
          state_nxt = PLAY;
          play_nxt  = 1'b1;
          rand_nxt  = spawn_vec;
          score_nxt = score_sat;
        end
      end
      st_over: begin
        if (start_s) begin
          state_nxt = OVER;
          over_nxt  = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge timer_clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      play_q  <= 1'b0;
      over_q  <= 1'b0;
      rand_q  <= '0;
      score_q <= '0;
    end else begin
      state   <= state_nxt;
      play_q  <= play_nxt;
      over_q  <= over_nxt;
      rand_q  <= rand_nxt;
      score_q <= score_nxt;
    end
  end

  assign bus.play_flag     = play_q;
  assign bus.gameover_ctrl = over_q;
  assign bus.rand_out      = rand_q;
  assign bus.score         = score_q;
  assign bus.q_Play        = st_play;
  assign bus.q_Over        = st_over;
  assign bus.q_Idle        = ~(st_play | st_over);

endmodule

// File: tb/tb_nexys_starship_dispatch.sv
// Scoreboard bench: three parameterisations share stimulus and
// are compared each cycle against a behavioural model.
module tb_nexys_starship_dispatch;

  logic timer_clk = 1'b0;
  logic Reset;
  always #5 timer_clk = ~timer_clk;

  nexys_starship_dispatch_if #(.SCORE_W(8)) ifa ();
  nexys_starship_dispatch_if #(.SCORE_W(2)) ifb ();
  nexys_starship_dispatch_if #(.SCORE_W(8)) ifc ();

  nexys_starship_dispatch #(
    .LFSR_SEED(16'hACE1), .RAND_THRESH(8'd64),
    .MAX_ACTIVE(2), .SCORE_W(8)
  ) dut_a (.timer_clk(timer_clk), .Reset(Reset), .bus(ifa));

  nexys_starship_dispatch #(
    .LFSR_SEED(16'h0004), .RAND_THRESH(8'd255),
    .MAX_ACTIVE(2), .SCORE_W(2)
  ) dut_b (.timer_clk(timer_clk), .Reset(Reset), .bus(ifb));

  nexys_starship_dispatch #(
    .LFSR_SEED(16'h0000), .RAND_THRESH(8'd0),
    .MAX_ACTIVE(4), .SCORE_W(8)
  ) dut_c (.timer_clk(timer_clk), .Reset(Reset), .bus(ifc));

  localparam int THR [3] = '{64, 255, 0};
  localparam int MAXA[3] = '{2, 2, 4};
  localparam int SMAX[3] = '{255, 3, 255};
  // zero seed on dut_c is expected to be replaced by 1
  localparam logic [15:0] SEEDS[3] = '{16'hACE1, 16'h0004, 16'h0001};

  int n_chk = 0;
  int n_err = 0;

  logic       in_start;
  logic [3:0] in_mon;
  logic [3:0] in_go;

  logic        m_st_q1, m_st_s;
  logic [3:0]  m_mon_q1, m_mon_s, m_go_q1, m_go_s;
  logic [3:0]  m_prev, m_fsm_mon;
  logic [15:0] m_lfsr [3];
  int          m_state[3];
  logic        m_play [3];
  logic        m_over [3];
  logic [3:0]  m_rand [3];
  int          m_score[3];

  logic [50:0] sb[$];
  int          sc_before;

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [16:0] pk(
    input logic p, input logic o, input logic [3:0] r,
    input logic [7:0] s, input logic qi, input logic qp,
    input logic qo);
    pk = {p, o, r, s, qi, qp, qo};
  endfunction

  function automatic logic [16:0] m_pk(input int k);
    m_pk = pk(m_play[k], m_over[k], m_rand[k], 8'(m_score[k]),
              m_state[k] == 0, m_state[k] == 1, m_state[k] == 2);
  endfunction

  task automatic m_reset();
    m_st_q1   = 1'b0;
    m_st_s    = 1'b0;
    m_mon_q1  = '0;
    m_mon_s   = '0;
    m_go_q1   = '0;
    m_go_s    = '0;
    m_prev    = '0;
    m_fsm_mon = '0;
    for (int k = 0; k < 3; k++) begin
      m_lfsr[k]  = SEEDS[k];
      m_state[k] = 0;
      m_play[k]  = 1'b0;
      m_over[k]  = 1'b0;
      m_rand[k]  = '0;
      m_score[k] = 0;
    end
  endtask

  task automatic m_step();
    logic [3:0] spawn;
    logic [1:0] idx;
    int         kills;
    int         tot;
    kills = $countones(m_prev & ~m_mon_s);
    for (int k = 0; k < 3; k++) begin
      idx   = m_lfsr[k][1:0];
      spawn = 4'b0000;
      if (int'(m_lfsr[k][9:2]) < THR[k] && !m_mon_s[idx]
          && $countones(m_mon_s) < MAXA[k])
        spawn[idx] = 1'b1;
      m_rand[k] = 4'b0000;
      case (m_state[k])
        0: if (m_st_s) begin
          m_state[k] = 1;
          m_play[k]  = 1'b1;
          m_score[k] = 0;
        end
        1: if (m_go_s != 4'b0000) begin
          m_state[k] = 2;
          m_play[k]  = 1'b0;
          m_over[k]  = 1'b1;
        end else begin
          m_rand[k]  = spawn;
          tot        = m_score[k] + kills;
          m_score[k] = (tot > SMAX[k]) ? SMAX[k] : tot;
        end
        default: if (!m_st_s) begin
          m_state[k] = 0;
          m_over[k]  = 1'b0;
        end
      endcase
      if (m_lfsr[k][0]) m_lfsr[k] = (m_lfsr[k] >> 1) ^ 16'hB400;
      else              m_lfsr[k] = m_lfsr[k] >> 1;
    end
    m_fsm_mon = m_mon_s;
    m_prev    = m_mon_s;
    m_st_s    = m_st_q1;
    m_st_q1   = in_start;
    m_mon_s   = m_mon_q1;
    m_mon_q1  = in_mon;
    m_go_s    = m_go_q1;
    m_go_q1   = in_go;
  endtask

  initial m_reset();

  // Reset only rises while the clock is low, so a clock edge is
  // the only event that produces a scoreboard entry.
  always @(posedge timer_clk or posedge Reset) begin
    if (Reset) m_reset();
    else       m_step();
    if (timer_clk) sb.push_back({m_pk(0), m_pk(1), m_pk(2)});
  end

  always @(negedge timer_clk) begin
    logic [50:0] e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'(0), 32'(1));
    end else begin
      e = sb.pop_front();
      check("sb_a", 32'(pk(ifa.play_flag, ifa.gameover_ctrl,
            ifa.rand_out, ifa.score, ifa.q_Idle, ifa.q_Play,
            ifa.q_Over)), 32'(e[50:34]));
      check("sb_b", 32'(pk(ifb.play_flag, ifb.gameover_ctrl,
            ifb.rand_out, 8'(ifb.score), ifb.q_Idle, ifb.q_Play,
            ifb.q_Over)), 32'(e[33:17]));
      check("sb_c", 32'(pk(ifc.play_flag, ifc.gameover_ctrl,
            ifc.rand_out, ifc.score, ifc.q_Idle, ifc.q_Play,
            ifc.q_Over)), 32'(e[16:0]));
    end
  end

  task automatic drive(input logic s, input logic [3:0] m,
                       input logic [3:0] g);
    in_start = s;  in_mon = m;  in_go = g;
    ifa.start = s; ifa.monster = m; ifa.gameover_in = g;
    ifb.start = s; ifb.monster = m; ifb.gameover_in = g;
    ifc.start = s; ifc.monster = m; ifc.gameover_in = g;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge timer_clk);
    #1;
  endtask

  task automatic rand_run(input int n);
    for (int i = 0; i < n; i++) begin
      if (i % 4 == 0)
        drive(1'($urandom_range(0, 1)), 4'($urandom), 4'b0000);
      tick(1);
      check("thr0_c", 32'(ifc.rand_out), 32'(0));
      check("oh_a", 32'($countones(ifa.rand_out) <= 1), 32'(1));
      check("oh_b", 32'($countones(ifb.rand_out) <= 1), 32'(1));
      check("tgt_a", 32'(|(ifa.rand_out & m_fsm_mon)), 32'(0));
      check("tgt_b", 32'(|(ifb.rand_out & m_fsm_mon)), 32'(0));
    end
  endtask

  initial begin
    Reset = 1'b1;
    drive(1'b0, 4'b0000, 4'b0000);
    tick(3);
    check("rst_a", 32'(pk(ifa.play_flag, ifa.gameover_ctrl,
          ifa.rand_out, ifa.score, ifa.q_Idle, ifa.q_Play,
          ifa.q_Over)), 32'(17'b0_0_0000_00000000_1_0_0));
    @(negedge timer_clk);
    #1 Reset = 1'b0;
    tick(2);

    drive(1'b1, 4'b0000, 4'b0000);
    tick(2);
    check("pre_play", 32'(ifa.q_Play), 32'(0));
    tick(1);
    check("play_q", 32'(ifa.q_Play), 32'(1));
    check("play_flag", 32'(ifa.play_flag), 32'(1));
    check("score0", 32'(ifa.score), 32'(0));

    drive(1'b0, 4'b0101, 4'b0000);
    tick(6);
    drive(1'b0, 4'b0000, 4'b0000);
    tick(4);
    check("kill2", 32'(ifa.score), 32'(2));
    drive(1'b0, 4'b1000, 4'b0000);
    tick(4);
    drive(1'b0, 4'b0000, 4'b0000);
    tick(4);
    check("kill3", 32'(ifa.score), 32'(3));
    check("kill3_b", 32'(ifb.score), 32'(3));

    // start is ignored while playing; two monsters block spawns
    drive(1'b1, 4'b0011, 4'b0000);
    tick(3);
    repeat (200) begin
      tick(1);
      check("maxact_a", 32'(ifa.rand_out), 32'(0));
      check("maxact_b", 32'(ifb.rand_out), 32'(0));
    end
    check("still_play", 32'(ifa.q_Play), 32'(1));
    drive(1'b0, 4'b0000, 4'b0000);
    tick(4);
    drive(1'b0, 4'b0100, 4'b0000);
    tick(4);
    drive(1'b0, 4'b0000, 4'b0000);
    tick(4);
    check("kill6", 32'(ifa.score), 32'(6));
    check("kill6_c", 32'(ifc.score), 32'(6));
    check("sat_b", 32'(ifb.score), 32'(3));

    rand_run(3000);
    check("rand_play", 32'(ifa.q_Play), 32'(1));

    drive(1'b0, 4'b0010, 4'b0000);
    tick(6);
    sc_before = m_score[0];
    drive(1'b1, 4'b0000, 4'b0100);
    tick(2);
    check("go_wait", 32'(ifa.q_Over), 32'(0));
    tick(1);
    check("over_q", 32'(ifa.q_Over), 32'(1));
    check("go_ctrl", 32'(ifa.gameover_ctrl), 32'(1));
    check("go_play", 32'(ifa.play_flag), 32'(0));
    check("go_rand", 32'(ifa.rand_out), 32'(0));
    check("go_score", 32'(ifa.score), 32'(sc_before));
    tick(20);
    check("held_over", 32'(ifa.q_Over), 32'(1));
    check("held_ctrl", 32'(ifa.gameover_ctrl), 32'(1));
    check("held_score", 32'(ifa.score), 32'(sc_before));
    drive(1'b0, 4'b0000, 4'b0000);
    tick(3);
    check("back_idle", 32'(ifa.q_Idle), 32'(1));
    check("ctrl_clr", 32'(ifa.gameover_ctrl), 32'(0));
    drive(1'b1, 4'b0000, 4'b0000);
    tick(3);
    check("replay", 32'(ifa.q_Play), 32'(1));
    check("replay_sc", 32'(ifa.score), 32'(0));

    rand_run(300);
    drive(1'b1, 4'b0000, 4'b0000);
    @(negedge timer_clk);
    #1 Reset = 1'b1;
    #1;
    check("arst_a", 32'(pk(ifa.play_flag, ifa.gameover_ctrl,
          ifa.rand_out, ifa.score, ifa.q_Idle, ifa.q_Play,
          ifa.q_Over)), 32'(17'b0_0_0000_00000000_1_0_0));
    check("arst_b", 32'(pk(ifb.play_flag, ifb.gameover_ctrl,
          ifb.rand_out, 8'(ifb.score), ifb.q_Idle, ifb.q_Play,
          ifb.q_Over)), 32'(17'b0_0_0000_00000000_1_0_0));
    @(negedge timer_clk);
    #1 Reset = 1'b0;
    rand_run(600);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
